// File: rtl/word_tx_serializer.sv
// Word-to-byte serializer feeding the UART transmitter, MSB-first,
// with a one-word holding register and optional per-byte done timeout.
module word_tx_serializer #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8,
    parameter int DONE_TIMEOUT    = 0
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_word_valid,
    input  logic [DATA_WIDTH-1:0]      i_word,
    output logic                       o_word_ready,
    input  logic                       i_tx_done,
    output logic                       o_tx_signal,
    output logic [DATA_WIDTH_UART-1:0] o_tx_result,
    output logic                       o_word_done,
    output logic                       o_error,
    output logic                       o_busy
);

    localparam int BYTES = DATA_WIDTH / DATA_WIDTH_UART;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TW    = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST  = CW'(BYTES - 1);
    localparam logic [TW-1:0] TLAST = TW'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] shift;
    logic                  hold_valid;
    logic [CW-1:0]         cnt;
    logic [TW-1:0]         tcnt;

    logic accept;
    logic load;
    logic send;
    logic advance;
    logic finish;
    logic timeout;
    logic expired;

    // Ready is forced low during reset so no word slips in on the reset edge.
    assign o_word_ready = ~hold_valid & ~i_reset;
    assign accept       = i_word_valid & o_word_ready;
    assign o_busy       = (state != IDLE) | hold_valid;
    assign expired      = (DONE_TIMEOUT != 0) && (tcnt == TLAST);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        send     = 1'b0;
        advance  = 1'b0;
        finish   = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    load     = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                send     = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (i_tx_done) begin
                    if (cnt == LAST) begin
                        finish   = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        advance  = 1'b1;
                        state_nx = START;
                    end
                end else if (expired) begin
                    timeout  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            hold        <= '0;
            hold_valid  <= 1'b0;
            shift       <= '0;
            cnt         <= '0;
            tcnt        <= '0;
            o_tx_signal <= 1'b0;
            o_tx_result <= '0;
            o_word_done <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            if (load) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_valid <= 1'b1;
            end
            if (accept) begin
                hold <= i_word;
            end
            if (load) begin
                shift <= hold;
                cnt   <= '0;
            end else if (advance) begin
                shift <= shift << DATA_WIDTH_UART;
                cnt   <= cnt + 1'b1;
            end
            // Timeout count restarts with every byte request.
            if (send) begin
                o_tx_result <= shift[DATA_WIDTH-1 -: DATA_WIDTH_UART];
                tcnt        <= '0;
            end else if (state == WAIT && !i_tx_done) begin
                tcnt <= tcnt + 1'b1;
            end
            o_tx_signal <= send;
            o_word_done <= finish;
            o_error     <= timeout;
        end
    end

endmodule

// File: tb/tb_word_tx_serializer.sv
// Testbench for word_tx_serializer: UART responder, byte-queue model,
// directed scenarios and a randomized word stream.
module tb_word_tx_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        word_valid = 1'b0;
    logic [31:0] word = '0;
    logic        uart_done = 1'b0;
    logic        spur_done = 1'b0;
    logic        word_ready;
    logic        tx_signal;
    logic [7:0]  tx_result;
    logic        word_done;
    logic        error;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int tx_seen = 0;
    int done_seen = 0;
    int err_seen = 0;
    int timer = 0;
    int done_hold = 0;
    int resp_delay = 10;
    bit resp_en = 1'b1;
    bit resp_double = 1'b0;
    logic [31:0] mon_exp;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    word_tx_serializer #(
        .DATA_WIDTH     (32),
        .DATA_WIDTH_UART(8),
        .DONE_TIMEOUT   (16)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_word_valid(word_valid),
        .i_word      (word),
        .o_word_ready(word_ready),
        .i_tx_done   (uart_done | spur_done),
        .o_tx_signal (tx_signal),
        .o_tx_result (tx_result),
        .o_word_done (word_done),
        .o_error     (error),
        .o_busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART model: answers each request with a done pulse resp_delay cycles later.
    always @(negedge clk) begin
        if (rst) begin
            timer     = 0;
            done_hold = 0;
            uart_done = 1'b0;
        end else begin
            if (word_done) done_seen++;
            if (error) err_seen++;
            if (done_hold > 0) begin
                uart_done = 1'b1;
                done_hold--;
            end else begin
                uart_done = 1'b0;
            end
            if (timer > 0) begin
                timer--;
                if (timer == 0) begin
                    uart_done = 1'b1;
                    done_hold = resp_double ? 1 : 0;
                end
            end
            if (tx_signal) begin
                tx_seen++;
                if (exp_q.size() > 0) mon_exp = {24'h0, exp_q.pop_front()};
                else mon_exp = 32'h100;
                chk("tx_byte", 32'(tx_result), mon_exp);
                if (resp_en) timer = resp_delay;
            end
        end
    end

    task automatic send_word(input logic [31:0] w, input string tag);
        int n = 0;
        word = w;
        word_valid = 1'b1;
        while (word_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 32'(word_ready), 1);
        if (word_ready === 1'b1)
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || timer != 0 || done_hold != 0 || uart_done) && n < 3000);
        chk({tag, "_idle"}, 32'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    int t0, d0, e0, n;

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(word_ready), 0);
        chk("rst_tx_signal", 32'(tx_signal), 0);
        chk("rst_tx_result", 32'(tx_result), 0);
        chk("rst_word_done", 32'(word_done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 32'(word_ready), 1);

        // single word, done 10 cycles after each request
        t0 = tx_seen; d0 = done_seen;
        resp_delay = 10;
        send_word(32'h80E17021, "w1");
        wait_idle("w1");
        chk("w1_tx_cnt", tx_seen - t0, 4);
        chk("w1_done_cnt", done_seen - d0, 1);
        chk("w1_q_empty", exp_q.size(), 0);
        chk("w1_result_hold", 32'(tx_result), 32'h21);

        // back-to-back words through the holding register
        t0 = tx_seen; d0 = done_seen;
        resp_delay = 3;
        send_word(32'h01020304, "wa");
        send_word(32'hBFFFF021, "wb");
        chk("wb_busy", 32'(busy), 1);
        wait_idle("wab");
        chk("wab_tx_cnt", tx_seen - t0, 8);
        chk("wab_done_cnt", done_seen - d0, 2);
        chk("wab_q_empty", exp_q.size(), 0);

        // done never returned: timeout aborts the word
        t0 = tx_seen; d0 = done_seen; e0 = err_seen;
        resp_en = 1'b0;
        send_word(32'h12345678, "to");
        n = 0;
        while (!tx_signal && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("to_req", 32'(tx_signal), 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!error && n < 100);
        chk("to_latency", n, 16);
        chk("to_busy", 32'(busy), 0);
        chk("to_ready", 32'(word_ready), 1);
        exp_q.delete();
        @(negedge clk);
        chk("to_err_pulse", 32'(error), 0);
        repeat (2) @(negedge clk);
        chk("to_err_cnt", err_seen - e0, 1);
        chk("to_no_done", done_seen - d0, 0);
        chk("to_tx_cnt", tx_seen - t0, 1);
        resp_en = 1'b1;

        // reset mid-word with a second word queued
        t0 = tx_seen; d0 = done_seen; e0 = err_seen;
        resp_delay = 5;
        send_word(32'hDEADBEEF, "rm");
        send_word(32'h11223344, "rq");
        n = 0;
        while (tx_seen < t0 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rm_two_bytes", tx_seen - t0, 2);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("rm_tx_signal", 32'(tx_signal), 0);
        chk("rm_tx_result", 32'(tx_result), 0);
        chk("rm_word_done", 32'(word_done), 0);
        chk("rm_error", 32'(error), 0);
        chk("rm_busy", 32'(busy), 0);
        chk("rm_ready", 32'(word_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rm_rel_ready", 32'(word_ready), 1);
        chk("rm_no_done", done_seen - d0, 0);
        chk("rm_no_err", err_seen - e0, 0);
        t0 = tx_seen; d0 = done_seen;
        send_word(32'hCAFE0102, "rf");
        wait_idle("rf");
        chk("rf_tx_cnt", tx_seen - t0, 4);
        chk("rf_done_cnt", done_seen - d0, 1);
        chk("rf_q_empty", exp_q.size(), 0);

        // spurious done in IDLE and START, doubled done pulses
        t0 = tx_seen; d0 = done_seen;
        resp_double = 1'b1;
        resp_delay = 4;
        spur_done = 1'b1;
        repeat (3) @(negedge clk);
        chk("sp_idle_tx", 32'(tx_signal), 0);
        chk("sp_idle_busy", 32'(busy), 0);
        chk("sp_ready", 32'(word_ready), 1);
        word = 32'h5A0FF0A5;
        word_valid = 1'b1;
        for (int b = 3; b >= 0; b--) exp_q.push_back(word[8*b +: 8]);
        @(negedge clk);
        word_valid = 1'b0;
        chk("sp_lat_n1", 32'(tx_signal), 0);
        @(negedge clk);
        chk("sp_lat_n2", 32'(tx_signal), 0);
        @(negedge clk);
        spur_done = 1'b0;
        chk("sp_lat_n3", 32'(tx_signal), 1);
        wait_idle("sp");
        chk("sp_tx_cnt", tx_seen - t0, 4);
        chk("sp_done_cnt", done_seen - d0, 1);
        chk("sp_q_empty", exp_q.size(), 0);

        // randomized word stream
        t0 = tx_seen; d0 = done_seen; e0 = err_seen;
        for (int i = 0; i < 20; i++) begin
            resp_delay = int'($urandom_range(1, 12));
            resp_double = 1'($urandom_range(0, 1));
            send_word($urandom, "rnd");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle("rnd");
        chk("rnd_tx_cnt", tx_seen - t0, 80);
        chk("rnd_done_cnt", done_seen - d0, 20);
        chk("rnd_no_err", err_seen - e0, 0);
        chk("final_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
